encode_ds: RTL and testbench

//  - Data Share (LDS/GDS) instruction encoder: takes one ds_inst_t and serializes it as two 32-bit

---
 rtl/encode_ds.sv | 118 +++++++++++
 tb/tb_encode_ds.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/encode_ds.sv
// encode_ds: serializes one Data Share instruction into two 32-bit words
// (word0 then word1) with valid/ready on both sides and registered outputs.
// Optional macro ENCODE_DS_PREFETCH_EN lets the next instruction be accepted
// in the same cycle that word1 is transferred, giving 2 cycles/instruction.

package encode_ds_pkg;
    typedef struct packed {
        logic [7:0] offset0;
        logic [7:0] offset1;
        logic       gds;
        logic [7:0] op;
        logic [7:0] addr;
        logic [7:0] data0;
        logic [7:0] data1;
        logic [7:0] vdst;
    } ds_inst_t;
endpackage

module encode_ds
    import encode_ds_pkg::*;
#(
    parameter logic [5:0] DS_ENCODING = 6'b110110,
    parameter int         CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  ds_inst_t         ds_inst_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      inst_out,
    output logic             out_last,
    output logic [CNT_W-1:0] enc_count
);

    typedef enum logic [1:0] {IDLE, WORD0, WORD1} state_t;

    state_t           r_state;
    ds_inst_t         r_hold;
    logic [31:0]      r_inst_out;
    logic             r_out_valid;
    logic             r_out_last;
    logic [CNT_W-1:0] r_count;
    logic             w_accept;

    // Field packing mirrors the DS decoder; bit 16 is reserved and always 0.
    function automatic logic [31:0] f_word0(input ds_inst_t d);
        return {DS_ENCODING, d.op, d.gds, 1'b0, d.offset1, d.offset0};
    endfunction

    function automatic logic [31:0] f_word1(input ds_inst_t d);
        return {d.vdst, d.data1, d.data0, d.addr};
    endfunction

    // Prefetch mode may take a new instruction while word1 is leaving.
`ifdef ENCODE_DS_PREFETCH_EN
    assign in_ready = (r_state == IDLE) || ((r_state == WORD1) && out_ready);
`else
    assign in_ready = (r_state == IDLE);
`endif

    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_out_valid;
    assign inst_out  = r_inst_out;
    assign out_last  = r_out_last;
    assign enc_count = r_count;

    // Encoder FSM: accept -> word0 -> word1, outputs held while stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_hold      <= '0;
            r_inst_out  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_count     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_hold      <= ds_inst_in;
                        r_inst_out  <= f_word0(ds_inst_in);
                        r_out_valid <= 1'b1;
                        r_out_last  <= 1'b0;
                        r_state     <= WORD0;
                    end
                end
                WORD0: begin
                    if (out_ready) begin
                        r_inst_out <= f_word1(r_hold);
                        r_out_last <= 1'b1;
                        r_state    <= WORD1;
                    end
                end
                WORD1: begin
                    if (out_ready) begin
                        r_count <= r_count + 1'b1;
                        if (w_accept) begin
                            // Only reachable in prefetch mode: no bubble.
                            r_hold      <= ds_inst_in;
                            r_inst_out  <= f_word0(ds_inst_in);
                            r_out_valid <= 1'b1;
                            r_out_last  <= 1'b0;
                            r_state     <= WORD0;
                        end else begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_state     <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_encode_ds.sv
// Directed bench for encode_ds: a 16-bit-counter instance plus a CNT_W=2
// instance on the same stimulus for the counter-wrap check.
module tb_encode_ds;
    import encode_ds_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        out_ready;
    ds_inst_t    ds_inst_in;
    logic        in_ready, out_valid, out_last;
    logic [31:0] inst_out;
    logic [15:0] enc_count;
    logic        d2_in_ready, d2_out_valid, d2_out_last;
    logic [31:0] d2_inst_out;
    logic [1:0]  d2_enc_count;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    encode_ds u_dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .ds_inst_in(ds_inst_in), .out_valid(out_valid), .out_ready(out_ready),
        .inst_out(inst_out), .out_last(out_last), .enc_count(enc_count)
    );

    encode_ds #(.CNT_W(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(d2_in_ready),
        .ds_inst_in(ds_inst_in), .out_valid(d2_out_valid), .out_ready(out_ready),
        .inst_out(d2_inst_out), .out_last(d2_out_last), .enc_count(d2_enc_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full instruction with out_ready high: accept, word0, word1.
    task automatic send(input ds_inst_t x, input logic [31:0] e0, input logic [31:0] e1,
                        input string tag);
        in_valid = 1'b1; ds_inst_in = x; out_ready = 1'b1;
        step(); in_valid = 1'b0;
        chk({tag, "_w0"}, inst_out, e0);
        chk({tag, "_w0last"}, {31'd0, out_last}, 32'd0);
        step();
        chk({tag, "_w1"}, inst_out, e1);
        chk({tag, "_w1last"}, {31'd0, out_last}, 32'd1);
        step();
        chk({tag, "_idle"}, {31'd0, out_valid}, 32'd0);
    endtask

    ds_inst_t inst_a, inst_b, inst_c;
    int cycles, bubbles, accepts;
    logic [1:0] wrap_exp [5];

    initial begin
        // A: op 0D, off1 12, off0 34 -> 110110_00001101_0_0 = D834, word0 D8341234
        inst_a = '{offset0:8'h34, offset1:8'h12, gds:1'b0, op:8'h0D,
                   addr:8'h05, data0:8'h06, data1:8'h07, vdst:8'h08};
        // B: gds 1, op FF -> 110110_11111111_1_0 = DBFE, word0 DBFE0000
        inst_b = '{offset0:8'h00, offset1:8'h00, gds:1'b1, op:8'hFF,
                   addr:8'h00, data0:8'h00, data1:8'h00, vdst:8'h00};
        // C: op 2A -> 110110_00101010_0_0 = D8A8, word0 D8A8A55A, word1 44332211
        inst_c = '{offset0:8'h5A, offset1:8'hA5, gds:1'b0, op:8'h2A,
                   addr:8'h11, data0:8'h22, data1:8'h33, vdst:8'h44};
        wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; ds_inst_in = '0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_last", {31'd0, out_last}, 32'd0);
        chk("rst_inst", inst_out, 32'd0);
        chk("rst_cnt", {16'd0, enc_count}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);

        // Single encode, then count and ready return.
        send(inst_a, 32'hD8341234, 32'h08070605, "single");
        chk("single_cnt", {16'd0, enc_count}, 32'd1);
        chk("single_ready", {31'd0, in_ready}, 32'd1);

        // GDS set, reserved bit 16 stays zero.
        send(inst_b, 32'hDBFE0000, 32'h00000000, "gds");
        in_valid = 1'b1; ds_inst_in = inst_b; out_ready = 1'b0;
        step(); in_valid = 1'b0;
        chk("gds_bit16", {31'd0, inst_out[16]}, 32'd0);
        chk("gds_bit17", {31'd0, inst_out[17]}, 32'd1);
        out_ready = 1'b1; step(); step();
        chk("gds_cnt", {16'd0, enc_count}, 32'd3);

        // Backpressure: 5 stalls in WORD0, 3 in WORD1; input changes ignored.
        in_valid = 1'b1; ds_inst_in = inst_c; out_ready = 1'b0;
        step(); in_valid = 1'b0; ds_inst_in = inst_b;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_w0_inst", inst_out, 32'hD8A8A55A);
            chk("bp_w0_vld", {30'd0, out_valid, out_last}, 32'd2);
            chk("bp_w0_rdy", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_w1_inst", inst_out, 32'h44332211);
            chk("bp_w1_vld", {30'd0, out_valid, out_last}, 32'd3);
            chk("bp_w1_rdy", {31'd0, in_ready}, 32'd0);
            chk("bp_w1_cnt", {16'd0, enc_count}, 32'd3);
        end
        out_ready = 1'b1; step();
        chk("bp_done_cnt", {16'd0, enc_count}, 32'd4);
        chk("bp_done_vld", {31'd0, out_valid}, 32'd0);

        // Back-to-back, 4 instructions.
        cycles = 0; bubbles = 0; accepts = 0;
        in_valid = 1'b1; ds_inst_in = inst_a; out_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (in_valid && in_ready) accepts++;
            step(); cycles++;
            if (accepts == 4) in_valid = 1'b0;
            if (enc_count == 16'd8) break;
            if (!out_valid) bubbles++;
        end
        in_valid = 1'b0;
        chk("b2b_cnt", {16'd0, enc_count}, 32'd8);
`ifdef ENCODE_DS_PREFETCH_EN
        chk("b2b_cycles", cycles, 32'd8);
        chk("b2b_bubbles", bubbles, 32'd0);
`else
        chk("b2b_cycles", cycles, 32'd12);
        chk("b2b_bubbles", bubbles, 32'd3);
`endif
        chk("b2b_cnt2", {30'd0, d2_enc_count}, 32'd0);

        // Async reset while stalled in WORD1.
        in_valid = 1'b1; ds_inst_in = inst_c; out_ready = 1'b1;
        step(); in_valid = 1'b0;
        step(); out_ready = 1'b0;
        step();
        chk("mid_pre_last", {31'd0, out_last}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_vld", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_last", {31'd0, out_last}, 32'd0);
        chk("mid_rst_inst", inst_out, 32'd0);
        chk("mid_rst_cnt", {16'd0, enc_count}, 32'd0);
        #2 reset_n = 1'b1;
        chk("mid_rel_rdy", {31'd0, in_ready}, 32'd1);

        // Restart at word0, then wrap of the 2-bit counter over 5 encodes.
        send(inst_c, 32'hD8A8A55A, 32'h44332211, "post_rst");
        chk("wrap_0", {30'd0, d2_enc_count}, {30'd0, wrap_exp[0]});
        for (int k = 1; k < 5; k++) begin
            send(inst_a, 32'hD8341234, 32'h08070605, "wrap_enc");
            chk("wrap_k", {30'd0, d2_enc_count}, {30'd0, wrap_exp[k]});
        end
        chk("wrap_cnt16", {16'd0, enc_count}, 32'd5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
